// File: rtl/pixel_pkg.sv
// Shared pixel/coordinate widths and sum types for the Bayer-to-gray path.
package pixel_pkg;

  localparam int DATA_W = 12;
  localparam int CNT_W  = 11;

  typedef logic [DATA_W-1:0] pixel_t;
  typedef logic [CNT_W-1:0]  coord_t;
  typedef logic [DATA_W:0]   pair_sum_t;
  typedef logic [DATA_W+1:0] quad_sum_t;

endpackage

// File: rtl/bayer_line_buf.sv
// Half-width line buffer of upper-row pair sums with per-entry valid bits.
// Single address port: a write (even row) and a read (odd row) never coincide.
module bayer_line_buf
  import pixel_pkg::*;
#(
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  pair_sum_t         wr_data,
  input  logic              rd_en,
  output pair_sum_t         rd_data,
  input  logic              valid_clr,
  output logic              valid_at
);

  pair_sum_t  mem [DEPTH];
  pair_sum_t  rd_data_reg;
  logic [DEPTH-1:0] valid_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem[addr];
    end
  end

  // Valid bits are flops so they can be cleared asynchronously; the data array is not.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_valid
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
        end else if (wr_en && (int'(addr) == gi)) begin
          valid_reg[gi] <= 1'b1;
        end else if (valid_clr && (int'(addr) == gi)) begin
          valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign rd_data  = rd_data_reg;
  assign valid_at = valid_reg[addr];

endmodule

// File: rtl/bayer_to_gray.sv
// Averages each 2x2 Bayer quad into one gray pixel, emitting a half-resolution
// stream with its own coordinates and a one-cycle valid strobe.
module bayer_to_gray
  import pixel_pkg::*;
#(
  parameter int IMG_WIDTH = 1280
) (
  input  logic   iCLK,
  input  logic   iRST,
  input  coord_t iX_Cont,
  input  coord_t iY_Cont,
  input  pixel_t iDATA,
  input  logic   iDVAL,
  output coord_t oX_Cont,
  output coord_t oY_Cont,
  output pixel_t oDATA,
  output logic   oDVAL
);

  localparam int DEPTH  = IMG_WIDTH / 2;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pixel_t            hold_reg;
  coord_t            x_reg, y_reg;
  pixel_t            data_reg;
  logic              dval_reg;

  logic              accept;
  logic              odd_row, odd_col;
  logic [ADDR_W-1:0] addr;
  logic              wr_en, rd_en, fire, valid_at;
  pair_sum_t         pair_sum, rd_data;
  quad_sum_t         quad_sum;

  assign accept  = iDVAL && (int'(iX_Cont) < IMG_WIDTH);
  assign odd_row = iY_Cont[0];
  assign odd_col = iX_Cont[0];
  assign addr    = iX_Cont[ADDR_W:1];

  // The upper-row pair is prefetched on the odd row's even column, so the
  // registered RAM read is ready when the odd column arrives.
  assign wr_en    = accept && !odd_row && odd_col;
  assign rd_en    = accept && odd_row && !odd_col;
  assign fire     = accept && odd_row && odd_col && valid_at;
  assign pair_sum = pair_sum_t'(hold_reg) + pair_sum_t'(iDATA);
  assign quad_sum = quad_sum_t'(rd_data) + quad_sum_t'(hold_reg) + quad_sum_t'(iDATA);

  bayer_line_buf #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .clk       (iCLK),
    .rst       (iRST),
    .addr      (addr),
    .wr_en     (wr_en),
    .wr_data   (pair_sum),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .valid_clr (fire),
    .valid_at  (valid_at)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      hold_reg <= '0;
    end else if (accept && !odd_col) begin
      hold_reg <= iDATA;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      x_reg    <= '0;
      y_reg    <= '0;
      data_reg <= '0;
      dval_reg <= 1'b0;
    end else begin
      dval_reg <= fire;
      if (fire) begin
        data_reg <= quad_sum[DATA_W+1:2];
        x_reg    <= iX_Cont >> 1;
        y_reg    <= iY_Cont >> 1;
      end
    end
  end

  assign oX_Cont = x_reg;
  assign oY_Cont = y_reg;
  assign oDATA   = data_reg;
  assign oDVAL   = dval_reg;

endmodule

// File: doc/bayer_to_gray.md
Name: bayer_to_gray

Overview:
Upstream feeder for convolution_vertical. Consumes the raw 12-bit Bayer pixel stream from the sensor capture stage. Each 2x2 Bayer quad (R, G1, G2, B) becomes one grayscale pixel equal to the quad average. Emits a half-resolution gray stream with its own coordinates, in exactly the iX_Cont/iY_Cont/iDATA/iDVAL form the convolution stage consumes.

Parameters:
IMG_WIDTH, 1280, raw pixels per line; must be even. Line buffer depth is IMG_WIDTH/2.
DATA_W, 12, raw and gray pixel width.
CNT_W, 11, coordinate counter width.

Ports:
iCLK  input  1  pixel clock; all state on rising edge.
iRST  input  1  reset, asynchronous, active-high.
iX_Cont  input  CNT_W  raw column of iDATA.
iY_Cont  input  CNT_W  raw row of iDATA.
iDATA  input  DATA_W  raw Bayer pixel.
iDVAL  input  1  iDATA/iX_Cont/iY_Cont valid this cycle.
oX_Cont  output  CNT_W  gray column = raw column >> 1.
oY_Cont  output  CNT_W  gray row = raw row >> 1.
oDATA  output  DATA_W  gray pixel.
oDVAL  output  1  one-cycle strobe qualifying oDATA/oX_Cont/oY_Cont.

Behaviour:
- Reset (async, iRST=1): oDATA=0, oX_Cont=0, oY_Cont=0, oDVAL=0, pixel-hold register=0, all line-buffer valid bits cleared. Line-buffer data is not cleared.
- Samples are used only when iDVAL=1 and iX_Cont < IMG_WIDTH. All other cycles leave internal state untouched and force oDVAL=0 on the next edge.
- Even raw row (iY_Cont[0]=0):
  - even column: store iDATA in the hold register.
  - odd column: write pair sum hold+iDATA (DATA_W+1 bits) to buf[iX_Cont>>1] and set valid[iX_Cont>>1].
  - no output on even rows.
- Odd raw row (iY_Cont[0]=1):
  - even column: store iDATA in the hold register.
  - odd column: sum = buf[iX_Cont>>1] + hold + iDATA (DATA_W+2 bits). Truncate: oDATA = sum[DATA_W+1:2].
  - The odd-column step fires only if valid[iX_Cont>>1]=1. It then clears that valid bit.
- Latency: oDVAL rises on the clock edge that samples the odd-row/odd-column pixel, i.e. outputs are registered, 1 cycle.
  - oX_Cont = iX_Cont>>1 and oY_Cont = iY_Cont>>1, registered together with oDATA.
  - oDVAL is 0 on every other cycle.
- Stale data guard: if the valid bit is 0 (e.g. reset mid even row, or missing upper row), no output is produced for that quad.
- Read/write on the same address in the same cycle cannot occur, because row parity differs. The buffer is single-port (read-before-write not required).
- Saturation cannot occur: max sum 4*0xFFF = 0x3FFC gives 0xFFF.
- iDVAL gaps are tolerated anywhere; the hold register and buffer persist across gaps.
- Frame boundary: there is no explicit frame signal. A new frame at iY_Cont=0 overwrites the buffer naturally.
- Throughput: one raw pixel per clock; at most one gray pixel per two clocks.

Decomposition:
- Shared package pixel_pkg: DATA_W, CNT_W, and typedefs pixel_t (DATA_W), coord_t (CNT_W), pair_sum_t (DATA_W+1), quad_sum_t (DATA_W+2).
- One sub-module, bayer_line_buf: synchronous single-port RAM of IMG_WIDTH/2 x (DATA_W+1) plus a valid-bit vector. Valid bits are asynchronously cleared by iRST.
- Top holds the hold register, parity decode, adder, and output registers.

Test Plan:
- Quad average: row0 x0=100, x1=200; row1 x0=300, x1=400 -> one oDVAL pulse with oDATA=250, oX_Cont=0, oY_Cont=0, one cycle after the row1 x1 sample.
- Truncation and max: quad 1,1,1,2 -> oDATA=1. Quad all 0xFFF -> oDATA=0xFFF.
- Full 8x4 raw frame with a vertical stripe (cols 2-5 = 0xFFF, others 0):
  - exactly 8 pulses at gray (0..3, 0..1);
  - gray cols 1-2 = 0xFFF, cols 0 and 3 = 0;
  - oDVAL never asserted on even raw rows.
- iDVAL gaps: same 2x2 quad with 3 idle cycles inserted between each pixel -> identical oDATA=250. oDVAL low during gaps.
- Reset mid even row: assert iRST after row0 x1, then deliver row1 x0..x3 -> no oDVAL. All outputs read 0 during reset.
- Out-of-range column: iX_Cont=IMG_WIDTH with iDVAL=1 -> no buffer write, no oDVAL, state unchanged.
